// File: rtl/vga_box_overlay.sv
`default_nettype none
// =============================================================================
// Module      : vga_box_overlay
// Description : Two-stage VGA pixel colour stage: bouncing bordered box over
//               an optional grid, with syncs/active delayed to match.
// Revision    : 1.0 - initial release
// =============================================================================
module vga_box_overlay #(
  parameter int          H_BLANK    = 160,
  parameter int          V_BLANK    = 44,
  parameter int          H_ACT      = 640,
  parameter int          V_ACT      = 480,
  parameter int          BOX_W      = 100,
  parameter int          BOX_H      = 100,
  parameter int          BORDER     = 4,
  parameter int          STEP       = 2,
  parameter int          X0         = 270,
  parameter int          Y0         = 190,
  parameter logic [11:0] BORDER_RGB = 12'hFFF,
  parameter logic [11:0] FILL_RGB   = 12'h00F,
  parameter logic [11:0] GRID_RGB   = 12'h222
) (
  input  logic        TD_CLK,
  input  logic        reset,
  input  logic [10:0] x_cnt,
  input  logic [10:0] y_cnt,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        move_en,
  input  logic        grid_en,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        active_out,
  output logic        frame_tick,
  output logic [7:0]  bounce_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE_X = 2'd1,
    MOVE_Y = 2'd2
  } state_t;

  typedef struct packed {
    logic       hit;
    logic       up;
    logic [9:0] pos;
  } axis_t;

  localparam logic [10:0] H_LO  = 11'(H_BLANK);
  localparam logic [10:0] H_HI  = 11'(H_BLANK + H_ACT);
  localparam logic [10:0] V_LO  = 11'(V_BLANK);
  localparam logic [10:0] V_HI  = 11'(V_BLANK + V_ACT);
  localparam logic [10:0] BW    = 11'(BOX_W);
  localparam logic [10:0] BH    = 11'(BOX_H);
  localparam logic [10:0] BD    = 11'(BORDER);
  localparam logic [9:0]  X_MAX = 10'(H_ACT - BOX_W);
  localparam logic [9:0]  Y_MAX = 10'(V_ACT - BOX_H);

  // One frame step along an axis; up=1 means moving towards larger coords.
  function automatic axis_t step_axis(input logic [9:0] pos, input logic up,
                                      input logic [9:0] lim);
    axis_t res;
    res.hit = 1'b0;
    res.up  = up;
    res.pos = pos;
    if (up) begin
      if ({1'b0, pos} + 11'(STEP) >= {1'b0, lim}) begin
        res.pos = lim;
        res.up  = 1'b0;
        res.hit = 1'b1;
      end else begin
        res.pos = pos + 10'(STEP);
      end
    end else begin
      if (pos <= 10'(STEP)) begin
        res.pos = '0;
        res.up  = 1'b1;
        res.hit = 1'b1;
      end else begin
        res.pos = pos - 10'(STEP);
      end
    end
    return res;
  endfunction

  state_t      state_q, state_d;
  logic [9:0]  box_x_q, box_x_d, box_y_q, box_y_d;
  logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [7:0]  bounce_q, bounce_d;
  logic        frame_tick_q, frame_tick_d;
  logic        act1_q, act1_d, in_box1_q, in_box1_d, in_fill1_q, in_fill1_d;
  logic        on_grid1_q, on_grid1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  logic [11:0] rgb_q, rgb_d;
  logic        hs2_q, hs2_d, vs2_q, vs2_d, act2_q, act2_d;

  logic [10:0] px_w, py_w, bx_w, by_w;
  axis_t       ax_w, ay_w;

  assign px_w = {1'b0, 10'(x_cnt - H_LO)};
  assign py_w = {1'b0, 10'(y_cnt - V_LO)};
  assign bx_w = {1'b0, box_x_q};
  assign by_w = {1'b0, box_y_q};
  assign ax_w = step_axis(box_x_q, dir_x_q, X_MAX);
  assign ay_w = step_axis(box_y_q, dir_y_q, Y_MAX);

  always_comb begin
    act1_d     = (x_cnt >= H_LO) && (x_cnt < H_HI) && (y_cnt >= V_LO) && (y_cnt < V_HI);
    in_box1_d  = (px_w >= bx_w) && (px_w < bx_w + BW) &&
                 (py_w >= by_w) && (py_w < by_w + BH);
    in_fill1_d = (px_w >= bx_w + BD) && (px_w < bx_w + BW - BD) &&
                 (py_w >= by_w + BD) && (py_w < by_w + BH - BD);
    on_grid1_d = (px_w[5:0] == 6'd0) || (py_w[5:0] == 6'd0);
    hs1_d      = hsync_in;
    vs1_d      = vsync_in;

    if (!act1_q)                      rgb_d = 12'h000;
    else if (in_fill1_q)              rgb_d = FILL_RGB;
    else if (in_box1_q)               rgb_d = BORDER_RGB;
    else if (grid_en && on_grid1_q)   rgb_d = GRID_RGB;
    else                              rgb_d = 12'h000;
    hs2_d  = hs1_q;
    vs2_d  = vs1_q;
    act2_d = act1_q;

    frame_tick_d = vs1_q & ~vsync_in;

    state_d  = state_q;
    box_x_d  = box_x_q;
    box_y_d  = box_y_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    bounce_d = bounce_q;
    case (state_q)
      IDLE: begin
        if (frame_tick_q && move_en) state_d = MOVE_X;
      end
      MOVE_X: begin
        state_d  = MOVE_Y;
        box_x_d  = ax_w.pos;
        dir_x_d  = ax_w.up;
        bounce_d = bounce_q + {7'd0, ax_w.hit};
      end
      MOVE_Y: begin
        state_d  = IDLE;
        box_y_d  = ay_w.pos;
        dir_y_d  = ay_w.up;
        bounce_d = bounce_q + {7'd0, ay_w.hit};
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge TD_CLK or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      box_x_q      <= 10'(X0);
      box_y_q      <= 10'(Y0);
      dir_x_q      <= 1'b1;
      dir_y_q      <= 1'b1;
      bounce_q     <= 8'd0;
      frame_tick_q <= 1'b0;
      act1_q       <= 1'b0;
      in_box1_q    <= 1'b0;
      in_fill1_q   <= 1'b0;
      on_grid1_q   <= 1'b0;
      hs1_q        <= 1'b1;
      vs1_q        <= 1'b1;
      rgb_q        <= 12'h000;
      hs2_q        <= 1'b1;
      vs2_q        <= 1'b1;
      act2_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      box_x_q      <= box_x_d;
      box_y_q      <= box_y_d;
      dir_x_q      <= dir_x_d;
      dir_y_q      <= dir_y_d;
      bounce_q     <= bounce_d;
      frame_tick_q <= frame_tick_d;
      act1_q       <= act1_d;
      in_box1_q    <= in_box1_d;
      in_fill1_q   <= in_fill1_d;
      on_grid1_q   <= on_grid1_d;
      hs1_q        <= hs1_d;
      vs1_q        <= vs1_d;
      rgb_q        <= rgb_d;
      hs2_q        <= hs2_d;
      vs2_q        <= vs2_d;
      act2_q       <= act2_d;
    end
  end

  assign r          = rgb_q[11:8];
  assign g          = rgb_q[7:4];
  assign b          = rgb_q[3:0];
  assign hsync_out  = hs2_q;
  assign vsync_out  = vs2_q;
  assign active_out = act2_q;
  assign frame_tick = frame_tick_q;
  assign bounce_cnt = bounce_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_box_overlay.sv
`default_nettype none
// =============================================================================
// Module      : tb_vga_box_overlay
// Description : Self-checking bench; default instance plus a small-range
//               instance that bounces every frame, against a pixel/motion model.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_vga_box_overlay;

  logic        TD_CLK = 1'b0;
  logic        reset;
  logic [10:0] x_cnt, y_cnt;
  logic        hsync_in, vsync_in, move_en, grid_en;
  logic [3:0]  r0, g0, b0, r1, g1, b1;
  logic        hs0, vs0, ac0, ft0, hs1, vs1, ac1, ft1;
  logic [7:0]  bc0, bc1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 TD_CLK = ~TD_CLK;

  vga_box_overlay dut0 (
    .TD_CLK(TD_CLK), .reset(reset), .x_cnt(x_cnt), .y_cnt(y_cnt),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .move_en(move_en), .grid_en(grid_en),
    .r(r0), .g(g0), .b(b0), .hsync_out(hs0), .vsync_out(vs0), .active_out(ac0),
    .frame_tick(ft0), .bounce_cnt(bc0)
  );

  vga_box_overlay #(.BOX_W(630), .BOX_H(470), .STEP(15), .X0(5), .Y0(5)) dut1 (
    .TD_CLK(TD_CLK), .reset(reset), .x_cnt(x_cnt), .y_cnt(y_cnt),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .move_en(move_en), .grid_en(grid_en),
    .r(r1), .g(g1), .b(b1), .hsync_out(hs1), .vsync_out(vs1), .active_out(ac1),
    .frame_tick(ft1), .bounce_cnt(bc1)
  );

  // Reference model: one box per instance, positions in active coordinates.
  int bw [2] = '{100, 630};
  int bh [2] = '{100, 470};
  int st [2] = '{2, 15};
  int x0 [2] = '{270, 5};
  int y0 [2] = '{190, 5};
  int bx [2], by [2], dx [2], dy [2], nb [2];

  typedef struct { int x; int y; } pt_t;
  typedef struct { logic [11:0] c0; logic [11:0] c1; logic hs; logic act; } exp_t;
  pt_t q_pts[$];

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      bx[d] = x0[d]; by[d] = y0[d]; dx[d] = 1; dy[d] = 1; nb[d] = 0;
    end
  endfunction

  function automatic void move_axis(inout int p, inout int dir, input int step,
                                    input int lim, inout int cnt);
    int np;
    np = p + dir * step;
    if (np >= lim)   begin p = lim; dir = -1; cnt++; end
    else if (np <= 0) begin p = 0; dir = 1; cnt++; end
    else p = np;
  endfunction

  function automatic void model_step(input int d);
    move_axis(bx[d], dx[d], st[d], 640 - bw[d], nb[d]);
    move_axis(by[d], dy[d], st[d], 480 - bh[d], nb[d]);
  endfunction

  function automatic bit is_act(input int x, input int y);
    return (x >= 160) && (x < 800) && (y >= 44) && (y < 524);
  endfunction

  function automatic logic [11:0] exp_rgb(input int d, input int x, input int y, input bit gr);
    int px, py;
    bit in_b, in_f;
    if (!is_act(x, y)) return 12'h000;
    px = x - 160;
    py = y - 44;
    in_b = px >= bx[d] && px < bx[d] + bw[d] && py >= by[d] && py < by[d] + bh[d];
    in_f = px >= bx[d] + 4 && px < bx[d] + bw[d] - 4 && py >= by[d] + 4 && py < by[d] + bh[d] - 4;
    if (in_f) return 12'h00F;
    if (in_b) return 12'hFFF;
    if (gr && ((px % 64) == 0 || (py % 64) == 0)) return 12'h222;
    return 12'h000;
  endfunction

  function automatic void add_pt(input int x, input int y);
    pt_t p;
    p.x = x; p.y = y;
    q_pts.push_back(p);
  endfunction

  // Probe points just around each box's outer edge and its border/fill boundary.
  function automatic void add_box_pts();
    int xs [8];
    int ys [5];
    for (int d = 0; d < 2; d++) begin
      xs = '{bx[d]-1, bx[d], bx[d]+3, bx[d]+4, bx[d]+bw[d]-5, bx[d]+bw[d]-4, bx[d]+bw[d]-1, bx[d]+bw[d]};
      ys = '{by[d]-1, by[d], by[d]+4, by[d]+bh[d]-1, by[d]+bh[d]};
      foreach (xs[i]) foreach (ys[j]) add_pt(160 + xs[i], 44 + ys[j]);
    end
  endfunction

  // Streams q_pts one per cycle, checking each result two cycles later.
  task automatic run_pts(input bit gr);
    exp_t hist[$];
    exp_t e;
    int   n;
    n = q_pts.size();
    grid_en = gr;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        x_cnt    = 11'(q_pts[i].x);
        y_cnt    = 11'(q_pts[i].y);
        hsync_in = 1'($urandom_range(0, 1));
        e.c0  = exp_rgb(0, q_pts[i].x, q_pts[i].y, gr);
        e.c1  = exp_rgb(1, q_pts[i].x, q_pts[i].y, gr);
        e.hs  = hsync_in;
        e.act = is_act(q_pts[i].x, q_pts[i].y);
        hist.push_back(e);
      end
      @(posedge TD_CLK); #1;
      if (i >= 1) begin
        e = hist.pop_front();
        chk("rgb0", {r0, g0, b0}, e.c0);
        chk("rgb1", {r1, g1, b1}, e.c1);
        chk("sync_act", {6'd0, hs0, vs0, ac0, hs1, vs1, ac1},
            {6'd0, e.hs, 1'b1, e.act, e.hs, 1'b1, e.act});
      end
    end
    q_pts.delete();
  endtask

  task automatic run_random(input int n, input bit gr);
    for (int i = 0; i < n; i++) add_pt($urandom_range(0, 850), $urandom_range(0, 540));
    run_pts(gr);
  endtask

  task automatic frame(input bit drop_en, input bit rst_mid);
    bit mv;
    mv       = move_en;
    hsync_in = 1'b1;
    vsync_in = 1'b0;
    @(posedge TD_CLK); #1;
    vsync_in = 1'b1;
    chk("frame_tick_hi", {10'd0, ft0, ft1}, 12'h003);
    @(posedge TD_CLK); #1;
    chk("tick_lo_vsync_out", {10'd0, ft0, vs0}, 12'h000);
    if (drop_en) move_en = 1'b0;
    if (rst_mid) begin
      reset = 1'b0;
      #1;
      chk("mid_reset", {bc0, hs0, vs0, ac0, ft0}, 12'h00C);
      model_reset();
      #3 reset = 1'b1;
    end else if (mv) begin
      model_step(0);
      model_step(1);
    end
    repeat (3) @(posedge TD_CLK);
    #1;
    chk("bounce0", {4'd0, bc0}, 12'(nb[0] % 256));
    chk("bounce1", {4'd0, bc1}, 12'(nb[1] % 256));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    int prev0;
    bit hit_last;
    reset    = 1'b0;
    move_en  = 1'b0;
    grid_en  = 1'b1;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    x_cnt    = '0;
    y_cnt    = '0;
    model_reset();

    // Counters and syncs running while held in reset.
    for (int i = 0; i < 8; i++) begin
      x_cnt    = 11'($urandom_range(150, 500));
      y_cnt    = 11'($urandom_range(40, 300));
      hsync_in = 1'($urandom_range(0, 1));
      vsync_in = 1'($urandom_range(0, 1));
      @(posedge TD_CLK); #1;
      chk("reset_rgb", {r0, g0, b0} | {r1, g1, b1}, 12'h000);
      chk("reset_ctl", {bc0, hs0, vs0, ac0, ft0}, 12'h00C);
    end
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    reset    = 1'b1;
    repeat (2) @(posedge TD_CLK);
    #1;

    add_pt(430, 234);
    run_pts(1'b0);
    add_pt(430, 234); add_pt(435, 240); add_pt(480, 280); add_pt(160, 44); add_pt(100, 100);
    run_pts(1'b1);
    add_pt(160, 44); add_pt(224, 44); add_pt(160, 108); add_pt(799, 523); add_pt(800, 300);
    run_pts(1'b0);
    run_random(300, 1'b1);
    run_random(100, 1'b0);

    move_en = 1'b1;
    frame(1'b0, 1'b0);
    add_box_pts();
    run_pts(1'b1);
    move_en = 1'b0;
    for (int i = 0; i < 5; i++) frame(1'b0, 1'b0);
    add_box_pts();
    run_pts(1'b0);

    // Long run: default box reaches the right edge; small box wraps bounce_cnt.
    move_en  = 1'b1;
    hit_last = 1'b0;
    for (int f = 0; f < 200; f++) begin
      prev0 = nb[0];
      frame(1'b0, 1'b0);
      if (nb[0] != prev0 || hit_last || (f % 25) == 0) begin
        add_box_pts();
        run_pts(1'($urandom_range(0, 1)));
      end
      hit_last = (nb[0] != prev0);
    end

    for (int f = 0; f < 60; f++) begin
      move_en = 1'($urandom_range(0, 1));
      frame(1'b0, 1'b0);
      if ((f % 15) == 0) begin
        add_box_pts();
        run_pts(1'b1);
      end
    end

    move_en = 1'b1;
    frame(1'b1, 1'b0);
    add_box_pts();
    run_pts(1'b1);

    move_en = 1'b1;
    frame(1'b0, 1'b1);
    add_box_pts();
    add_pt(430, 234);
    run_pts(1'b0);
    run_random(150, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
